// File: rtl/dbg_chain_select.sv
// Debug-chain module selector behind the JTAG TAP: decodes a select header, latches a module ID, routes DR traffic.
// Optional: define DBG_CHAIN_SEL_READBACK_EN to shift the currently latched ID out on tdo_o while a new one is shifted in.
module dbg_chain_select #(
  parameter int NUM_MODULES      = 4,
  parameter int MODULE_ID_LENGTH = 2
) (
  input  logic                   tck_pad_i,
  input  logic                   trst_pad_i,
  input  logic                   debug_select_i,
  input  logic                   capture_dr_i,
  input  logic                   shift_dr_i,
  input  logic                   update_dr_i,
  input  logic                   tdi_i,
  input  logic [NUM_MODULES-1:0] module_tdo_i,
  output logic [NUM_MODULES-1:0] module_select_o,
  output logic                   module_active_o,
  output logic                   tdo_o
);

  localparam int MID_W = MODULE_ID_LENGTH;
  localparam int CW    = $clog2(MODULE_ID_LENGTH + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] SEL  = 3'd2;
  localparam logic [2:0] IGN  = 3'd3;
  localparam logic [2:0] DATA = 3'd4;

  localparam logic [CW-1:0]  CNT_LAST = CW'(MODULE_ID_LENGTH - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(MODULE_ID_LENGTH);
  localparam logic [MID_W:0] NUM_MOD  = (MID_W+1)'(NUM_MODULES);

  logic [2:0]             state;
  logic [CW-1:0]          bit_cnt;
  logic [MID_W-1:0]       id_shift;
  logic [MID_W-1:0]       id_q;
  logic                   id_valid_q;
  logic [NUM_MODULES-1:0] id_hit;
  logic                   tdo_nxt;

  // Priority: reset > debug deselect > capture > update > shift; no strobe means Pause-DR hold.
  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      id_shift   <= '0;
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else if (!debug_select_i) begin
      state <= IDLE;
    end else if (capture_dr_i) begin
      state   <= HDR;
      bit_cnt <= '0;
    end else if (update_dr_i) begin
      if (state == IGN) begin
        id_q       <= id_shift;
        id_valid_q <= ({1'b0, id_shift} < NUM_MOD);
      end
      state <= IDLE;
    end else if (shift_dr_i) begin
      case (state)
        HDR: begin
          if (tdi_i) begin
            state    <= SEL;
            bit_cnt  <= '0;
            id_shift <= '0;
          end else begin
            state <= DATA;
          end
        end
        SEL: begin
          id_shift <= MID_W'({tdi_i, id_shift} >> 1);
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CNT_LAST) state <= IGN;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_MODULES; i++) begin : g_hit
    assign id_hit[i] = id_valid_q & (id_q == MID_W'(i));
  end

  assign module_select_o = id_hit & {NUM_MODULES{debug_select_i}};
  assign module_active_o = (state == DATA) & debug_select_i;

  always_comb begin
    tdo_nxt = 1'b0;
    case (state)
      DATA: tdo_nxt = |(id_hit & module_tdo_i);
      HDR:  tdo_nxt = id_valid_q;
`ifdef DBG_CHAIN_SEL_READBACK_EN
      SEL: begin
        // Old ID leaves LSB first in lockstep with the new ID bits arriving.
        tdo_nxt = id_q[0];
        for (int b = 0; b < MID_W; b++)
          if (bit_cnt == CW'(b)) tdo_nxt = id_q[b];
      end
      IGN:  tdo_nxt = id_valid_q;
`endif
      default: tdo_nxt = 1'b0;
    endcase
  end

  always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) tdo_o <= 1'b0;
    else            tdo_o <= tdo_nxt;
  end

endmodule

// File: tb/tb_dbg_chain_select.sv
// Randomized bench for dbg_chain_select against a session-level model (shift counts and collected ID bits).
module tb_dbg_chain_select;
  localparam int NM  = 3;
  localparam int MIL = 2;

  logic          tck = 1'b0;
  logic          trst;
  logic          dsel, cap, sh, upd, tdi;
  logic [NM-1:0] mtdo;
  logic [NM-1:0] msel;
  logic          mact;
  logic          tdo;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a DR session is alive after capture; everything follows from how many shifts happened since.
  int sess, nsh, new_id, mid;
  bit hdr, mvalid;

  dbg_chain_select #(.NUM_MODULES(NM), .MODULE_ID_LENGTH(MIL)) dut (
    .tck_pad_i(tck), .trst_pad_i(trst), .debug_select_i(dsel),
    .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd), .tdi_i(tdi),
    .module_tdo_i(mtdo), .module_select_o(msel), .module_active_o(mact), .tdo_o(tdo)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // 0 idle, 1 header, 2 id bits, 3 ignore, 4 data
  function automatic int phase();
    if (sess == 0) return 0;
    if (nsh == 0)  return 1;
    if (!hdr)      return 4;
    if (nsh <= MIL) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_sel();
    return (dsel && mvalid) ? (32'd1 << mid) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_act();
    return (phase() == 4 && dsel) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_tdo();
    case (phase())
      4: return (mvalid && mtdo[mid]) ? 32'd1 : 32'd0;
      1: return {31'd0, mvalid};
`ifdef DBG_CHAIN_SEL_READBACK_EN
      2: return (mid >> (nsh - 1)) & 1;
      3: return {31'd0, mvalid};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    if (!dsel) sess = 0;
    else if (cap) begin
      sess = 1; nsh = 0; new_id = 0;
    end else if (upd) begin
      if (sess != 0 && hdr && nsh > MIL) begin
        mid = new_id;
        mvalid = (new_id < NM);
      end
      sess = 0;
    end else if (sh && sess != 0) begin
      if (nsh == 0) hdr = tdi;
      else if (hdr && nsh <= MIL) new_id += int'(tdi) << (nsh - 1);
      nsh++;
    end
  endtask

  task automatic model_reset();
    sess = 0; nsh = 0; new_id = 0; mid = 0; mvalid = 0; hdr = 0;
  endtask

  task automatic step(input logic d, input logic c, input logic s, input logic u,
                      input logic t, input logic [NM-1:0] m);
    dsel = d; cap = c; sh = s; upd = u; tdi = t; mtdo = m;
    #1;
    chk("sel_pre", 32'(msel), exp_sel());
    chk("act_pre", 32'(mact), exp_act());
    @(posedge tck);
    model_edge();
    #1;
    chk("sel", 32'(msel), exp_sel());
    chk("act", 32'(mact), exp_act());
    @(negedge tck);
    #1;
    chk("tdo", 32'(tdo), exp_tdo());
  endtask

  task automatic rnd_m(output logic [NM-1:0] m);
    m = NM'($urandom);
  endtask

  task automatic sel_cmd(input int id, input int nbits);
    logic [NM-1:0] m;
    rnd_m(m); step(1, 1, 0, 0, 0, m);
    rnd_m(m); step(1, 0, 1, 0, 1, m);
    for (int b = 0; b < nbits; b++) begin
      rnd_m(m); step(1, 0, 1, 0, logic'((id >> b) & 1), m);
    end
    rnd_m(m); step(1, 0, 0, 1, 0, m);
    rnd_m(m); step(1, 0, 0, 0, 0, m);
  endtask

  task automatic data_xfer(input int n);
    logic [NM-1:0] m;
    rnd_m(m); step(1, 1, 0, 0, 0, m);
    rnd_m(m); step(1, 0, 1, 0, 0, m);
    for (int b = 0; b < n; b++) begin
      rnd_m(m); step(1, 0, 1, 0, logic'($urandom_range(0, 1)), m);
    end
    rnd_m(m); step(1, 0, 0, 1, 0, m);
  endtask

  task automatic reset_pulse();
    #1 trst = 1'b1;
    #1;
    chk("rst_sel", 32'(msel), 32'd0);
    chk("rst_act", 32'(mact), 32'd0);
    chk("rst_tdo", 32'(tdo), 32'd0);
    model_reset();
    trst = 1'b0;
  endtask

  initial begin
    logic [NM-1:0] m;
    trst = 1'b1; dsel = 0; cap = 0; sh = 0; upd = 0; tdi = 0; mtdo = '0;
    model_reset();
    #2;
    chk("init_sel", 32'(msel), 32'd0);
    chk("init_act", 32'(mact), 32'd0);
    chk("init_tdo", 32'(tdo), 32'd0);
    @(negedge tck); #1 trst = 1'b0;

    // Select module 2, then pass data through it.
    sel_cmd(2, 2);
    chk("sel2", 32'(msel), 32'b100);
    data_xfer(8);
    // Invalid ID 3 with three modules.
    sel_cmd(3, 2);
    chk("sel_inv", 32'(msel), 32'd0);
    data_xfer(4);
    // Truncated command leaves the prior selection alone.
    sel_cmd(1, 2);
    sel_cmd(2, 1);
    chk("trunc", 32'(msel), 32'b010);
    // Readback path: old ID 2 leaves while ID 1 arrives.
    sel_cmd(2, 2);
    sel_cmd(1, 2);
    chk("rb_sel", 32'(msel), 32'b010);
    // Deselect during data.
    step(1, 1, 0, 0, 0, '1); step(1, 0, 1, 0, 0, '1);
    step(1, 0, 1, 0, 1, '1); step(0, 0, 1, 0, 1, '1);
    // Capture during data returns to header.
    step(1, 1, 0, 0, 0, '1); step(1, 0, 1, 0, 0, '1);
    step(1, 0, 1, 0, 1, '1); step(1, 1, 0, 0, 0, '1);
    step(1, 0, 0, 0, 0, '1); step(1, 0, 1, 0, 0, '1);
    // Pause-DR holds mid-data.
    step(1, 0, 0, 0, 0, '1); step(1, 0, 1, 0, 0, '0);
    // Reset mid-shift.
    step(1, 0, 1, 0, 1, '1);
    reset_pulse();
    step(1, 0, 1, 0, 1, '1);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: sel_cmd($urandom_range(0, 3), $urandom_range(0, 3));
        3, 4:    data_xfer($urandom_range(0, 6));
        5:       reset_pulse();
        default: begin
          rnd_m(m);
          step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 5) == 0),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 5) == 0),
               logic'($urandom_range(0, 1)), m);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dbg_chain_select.md
Name: dbg_chain_select

Overview:
Debug-chain arbiter that sits behind the JTAG TAP controller when the DEBUG instruction is latched. It decodes a module-select header shifted into the debug data register and latches a module ID. It then routes DR shift traffic to exactly one of NUM_MODULES debug sub-units (CPU, bus, trace, ...). It returns that unit's serial output to the TAP as debug_tdi_i.

Parameters:
NUM_MODULES, 4, number of debug sub-units sharing the chain (1..2**MODULE_ID_LENGTH)
MODULE_ID_LENGTH, 2, width of module ID field in select command

Ports:
tck_pad_i  input  1  JTAG clock; all state on posedge, tdo_o on negedge
trst_pad_i  input  1  reset, asynchronous, active-high
debug_select_i  input  1  DEBUG instruction active (TAP debug_select_o)
capture_dr_i  input  1  TAP in Capture-DR
shift_dr_i  input  1  TAP in Shift-DR
update_dr_i  input  1  TAP in Update-DR
tdi_i  input  1  serial data from TAP (tdo_o)
module_tdo_i  input  NUM_MODULES  serial outputs of sub-units
module_select_o  output  NUM_MODULES  one-hot select of latched module, all-zero if none valid
module_active_o  output  1  pass-through live; sub-units qualify shift_dr with this
tdo_o  output  1  serial return to TAP debug_tdi_i

Behaviour:
- FSM states: IDLE, HDR, SEL, IGN, DATA. Posedge tck_pad_i. Async reset to IDLE.
- Any state, debug_select_i=0: next state IDLE. Priority is reset > debug_select_i=0 > capture > update > shift.
- capture_dr_i & debug_select_i: next state HDR, bit_cnt<=0. Applies from every state, including mid-DATA.
- HDR & shift_dr_i, tdi_i=1: next state SEL, bit_cnt<=0, id_shift<=0.
- HDR & shift_dr_i, tdi_i=0: next state DATA. The header bit is consumed and not forwarded as data.
- SEL & shift_dr_i: id_shift<={tdi_i, id_shift[MSB:1]} (LSB first), bit_cnt++. The shift with bit_cnt==MODULE_ID_LENGTH-1 goes to IGN.
- IGN & shift_dr_i: bits discarded, stay IGN.
- DATA & shift_dr_i: stay DATA.
- Pause-DR (no capture/shift/update asserted): state holds.
- update_dr_i & debug_select_i in IGN:
  - id_q<=id_shift
  - id_valid_q<=(id_shift < NUM_MODULES)
  - next state IDLE
- update_dr_i in SEL (fewer than MODULE_ID_LENGTH ID bits shifted): id_q/id_valid_q unchanged, next state IDLE (truncated command discarded).
- update_dr_i in HDR or DATA: id_q/id_valid_q unchanged, next state IDLE.
- Reset values: id_q=0, id_valid_q=0, bit_cnt=0, tdo_o=0, module_select_o=0, module_active_o=0.
- module_select_o[i] = debug_select_i & id_valid_q & (id_q==i). Combinational from registers. Changes the cycle after update_dr.
- module_active_o = (state==DATA) & debug_select_i. Combinational.
- tdo_o is registered on negedge tck_pad_i. Next value:
  - DATA with id_valid_q: module_tdo_i[id_q].
  - DATA without id_valid_q: 0.
  - HDR: id_valid_q (status bit).
  - SEL, IGN: see optional feature.
  - IDLE: 0.
- Sub-unit latency: a tdi bit presented on posedge N in DATA reaches the sub-unit on the same edge via tdi_i. Its output is returned on the following negedge.
- bit_cnt is $clog2(MODULE_ID_LENGTH+1) wide and saturates, so there is no wrap in IGN.

Optional Feature:
DBG_CHAIN_SEL_READBACK_EN
- Defined: in SEL, tdo_o shifts out the currently latched id_q LSB first, indexed by bit_cnt. In IGN, tdo_o=id_valid_q. A host can read back the old ID while writing the new one.
- Undefined: tdo_o=0 in SEL and IGN; no readback mux.

Test Plan:
- Reset:
  - Stimulus: trst_pad_i pulse mid-shift.
  - Response: module_select_o=0000, module_active_o=0, tdo_o=0, state IDLE immediately (async).
- Select module 2:
  - Stimulus: DEBUG; capture, shift bits 1,0,1 (header, ID LSB first), update.
  - Response: module_select_o=0100 the cycle after update; HDR-phase tdo_o=0 (no prior valid ID).
- Data pass-through:
  - Stimulus: module 2 selected; capture, shift 0 then 8 data bits with module_tdo_i[2] toggling.
  - Response: module_active_o=1 for the 8 data shifts; tdo_o equals module_tdo_i[2] each negedge; HDR-phase tdo_o=1.
- Invalid or truncated select:
  - Stimulus A: NUM_MODULES=3, select ID 3 (bits 1,1,1). Response: module_select_o=000, id_valid_q=0, DATA tdo_o=0.
  - Stimulus B: a later select shifting only 1 ID bit then update. Response: prior selection unchanged.
- Abort paths:
  - Stimulus A: debug_select_i dropped during DATA. Response: module_active_o=0, module_select_o=0 the same cycle; IDLE next edge.
  - Stimulus B: capture_dr_i during DATA. Response: back to HDR.
- Readback (DBG_CHAIN_SEL_READBACK_EN defined):
  - Stimulus: id_q=2; new select of 1.
  - Response: tdo_o in SEL = 0,1; after update module_select_o=0010.
